// File: rtl/ecc_pkg.sv
// ecc_pkg: shared definitions for the SECDED (extended Hamming) encoder,
// decoder and scrubber.
//   ecc_r(data_w)       : number of Hamming check bits for a data width
//   is_pow2(x)          : true when x is a power of two (check-bit position)
//   ecc_pos_of_data(i)  : codeword position (1-based) of data bit i
//   ecc_data_of_pos(p)  : data bit index held at position p, or -1
//   ecc_status_t        : per-word decode outcome
package ecc_pkg;

    typedef enum logic [1:0] {
        CLEAN = 2'd0,
        SEC   = 2'd1,
        DED   = 2'd2
    } ecc_status_t;

    // Smallest r with 2^r >= data_w + r + 1.
    function automatic int ecc_r(input int data_w);
        int r;
        r = 1;
        while ((1 << r) < data_w + r + 1) r++;
        return r;
    endfunction

    function automatic bit is_pow2(input int x);
        return (x > 0) && ((x & (x - 1)) == 0);
    endfunction

    // Data bits fill the non-power-of-two positions LSB-first.
    function automatic int ecc_pos_of_data(input int idx);
        int cnt;
        cnt = 0;
        for (int pos = 1; pos <= 512; pos++) begin
            if (!is_pow2(pos)) begin
                if (cnt == idx) return pos;
                cnt++;
            end
        end
        return 0;
    endfunction

    // Below a non-power-of-two position p there are $clog2(p) check
    // positions, so the data index is p - $clog2(p) - 1.
    function automatic int ecc_data_of_pos(input int pos);
        if (pos < 1 || is_pow2(pos)) return -1;
        return pos - $clog2(pos) - 1;
    endfunction

endpackage

// File: rtl/ecc_secded_syn.sv
// ecc_secded_syn: combinational SECDED syndrome generator.
//   data [DATA_W-1:0] : received data bits
//   ecc  [R:0]        : {p[R-1:0], p0}; p0 is the even overall parity
//   syn  [R-1:0]      : Hamming syndrome (erroneous position when single)
//   ovf               : overall parity failure
module ecc_secded_syn
    import ecc_pkg::*;
#(
    parameter  int DATA_W = 32,
    localparam int R      = ecc_r(DATA_W)
) (
    input  logic [DATA_W-1:0] data,
    input  logic [R:0]        ecc,
    output logic [R-1:0]      syn,
    output logic              ovf
);

    localparam int N = DATA_W + R;

    // Received word laid out by Hamming position.
    logic [N:1] cw;

    for (genvar i = 0; i < DATA_W; i++) begin : g_data
        assign cw[ecc_pos_of_data(i)] = data[i];
    end

    for (genvar k = 0; k < R; k++) begin : g_par
        assign cw[2**k] = ecc[k+1];
    end

    always_comb begin
        syn = '0;
        for (int j = 1; j <= N; j++) begin
            for (int k = 0; k < R; k++) begin
                if (j[k]) syn[k] = syn[k] ^ cw[j];
            end
        end
    end

    assign ovf = ecc[0] ^ (^cw);

endmodule

// File: rtl/ecc_secded_dec_pipe.sv
// ecc_secded_dec_pipe: 2-stage pipelined SECDED decoder with valid/ready
// flow control, saturating error counters and a first-error log.
//   clk, rst_n                  : clock, asynchronous active-low reset
//   in_valid/in_ready           : input handshake
//   in_data, in_ecc, corr_en    : received word, check bits, correct enable
//   out_valid/out_ready         : output handshake
//   out_data, out_sec, out_ded  : decoded data and error flags
//   out_syndrome                : raw syndrome of the beat
//   stat_clr                    : synchronous clear of counters and log
//   sec_cnt, ded_cnt            : saturating error counts
//   log_valid/log_syndrome/log_ded : first error since clear or reset
module ecc_secded_dec_pipe
    import ecc_pkg::*;
#(
    parameter  int DATA_W = 32,
    parameter  int CNT_W  = 16,
    localparam int R      = ecc_r(DATA_W),
    localparam int N      = DATA_W + R
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [R:0]        in_ecc,
    input  logic              corr_en,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_sec,
    output logic              out_ded,
    output logic [R-1:0]      out_syndrome,
    input  logic              stat_clr,
    output logic [CNT_W-1:0]  sec_cnt,
    output logic [CNT_W-1:0]  ded_cnt,
    output logic              log_valid,
    output logic [R-1:0]      log_syndrome,
    output logic              log_ded
);

    localparam logic [R-1:0] N_SYN = R'(N);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    logic              s1_adv, s2_adv;
    logic [R-1:0]      syn_p0;
    logic              ovf_p0;
    logic              vld_p1, ovf_p1, corr_p1;
    logic [DATA_W-1:0] data_p1;
    logic [R-1:0]      syn_p1;
    ecc_status_t       status_p1;
    logic [DATA_W-1:0] flip_mask_p1, data_corr_p1;

    // Stage 0: syndrome of the incoming word
    ecc_secded_syn #(.DATA_W(DATA_W)) u_syn (
        .data (in_data),
        .ecc  (in_ecc),
        .syn  (syn_p0),
        .ovf  (ovf_p0)
    );

    assign s2_adv   = !out_valid || out_ready;
    assign s1_adv   = !vld_p1 || s2_adv;
    assign in_ready = s1_adv;

    // Stage 1: raw data, syndrome, ovf and correction mode
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1  <= 1'b0;
            data_p1 <= '0;
            syn_p1  <= '0;
            ovf_p1  <= 1'b0;
            corr_p1 <= 1'b0;
        end else if (s1_adv) begin
            vld_p1  <= in_valid;
            data_p1 <= in_data;
            syn_p1  <= syn_p0;
            ovf_p1  <= ovf_p0;
            corr_p1 <= corr_en;
        end
    end

    // A syndrome beyond N names no real bit, so it is uncorrectable even
    // with odd overall parity.
    always_comb begin
        status_p1 = CLEAN;
        if (ovf_p1)
            status_p1 = (syn_p1 > N_SYN) ? DED : SEC;
        else if (syn_p1 != '0)
            status_p1 = DED;
    end

    // Syndrome 0 or a check-bit position matches no data bit, so those
    // single errors leave the data untouched.
    for (genvar i = 0; i < DATA_W; i++) begin : g_flip
        localparam logic [R-1:0] POS = R'(ecc_pos_of_data(i));
        assign flip_mask_p1[i] = (syn_p1 == POS);
    end

    assign data_corr_p1 = (status_p1 == SEC && corr_p1) ? (data_p1 ^ flip_mask_p1)
                                                        : data_p1;

    // Stage 2: corrected data and flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid    <= 1'b0;
            out_data     <= '0;
            out_sec      <= 1'b0;
            out_ded      <= 1'b0;
            out_syndrome <= '0;
        end else if (s2_adv) begin
            out_valid    <= vld_p1;
            out_data     <= data_corr_p1;
            out_sec      <= (status_p1 == SEC);
            out_ded      <= (status_p1 == DED);
            out_syndrome <= syn_p1;
        end
    end

    logic             hs_p2, err_p2;
    logic [CNT_W-1:0] sec_base, ded_base, sec_nxt, ded_nxt;
    logic             logv_base, logv_nxt, logded_nxt;
    logic [R-1:0]     logsyn_nxt;

    assign hs_p2  = out_valid && out_ready;
    assign err_p2 = out_sec || out_ded;

    // Clear first, then apply this cycle's handshaked beat on top.
    always_comb begin
        sec_base   = stat_clr ? '0 : sec_cnt;
        ded_base   = stat_clr ? '0 : ded_cnt;
        logv_base  = stat_clr ? 1'b0 : log_valid;
        sec_nxt    = (hs_p2 && out_sec) ? sat_inc(sec_base) : sec_base;
        ded_nxt    = (hs_p2 && out_ded) ? sat_inc(ded_base) : ded_base;
        logv_nxt   = logv_base;
        logsyn_nxt = stat_clr ? '0 : log_syndrome;
        logded_nxt = stat_clr ? 1'b0 : log_ded;
        if (hs_p2 && err_p2 && !logv_base) begin
            logv_nxt   = 1'b1;
            logsyn_nxt = out_syndrome;
            logded_nxt = out_ded;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sec_cnt      <= '0;
            ded_cnt      <= '0;
            log_valid    <= 1'b0;
            log_syndrome <= '0;
            log_ded      <= 1'b0;
        end else begin
            sec_cnt      <= sec_nxt;
            ded_cnt      <= ded_nxt;
            log_valid    <= logv_nxt;
            log_syndrome <= logsyn_nxt;
            log_ded      <= logded_nxt;
        end
    end

endmodule

// File: tb/tb_ecc_secded_dec_pipe.sv
// tb_ecc_secded_dec_pipe: directed bench for ecc_secded_dec_pipe
// (DATA_W = 32, CNT_W = 2) with a per-cycle reference model.
module tb_ecc_secded_dec_pipe;

    localparam int DW = 32;
    localparam int CW = 2;
    localparam int RW = 6;
    localparam int NP = 38;
    localparam int CMAX = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic [RW:0]   in_ecc = '0;
    logic          corr_en = 1'b1;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [DW-1:0] out_data;
    logic          out_sec;
    logic          out_ded;
    logic [RW-1:0] out_syndrome;
    logic          stat_clr = 1'b0;
    logic [CW-1:0] sec_cnt;
    logic [CW-1:0] ded_cnt;
    logic          log_valid;
    logic [RW-1:0] log_syndrome;
    logic          log_ded;

    int total = 0;
    int passes = 0;

    always #5 clk = ~clk;

    ecc_secded_dec_pipe #(.DATA_W(DW), .CNT_W(CW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .in_ecc       (in_ecc),
        .corr_en      (corr_en),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_sec      (out_sec),
        .out_ded      (out_ded),
        .out_syndrome (out_syndrome),
        .stat_clr     (stat_clr),
        .sec_cnt      (sec_cnt),
        .ded_cnt      (ded_cnt),
        .log_valid    (log_valid),
        .log_syndrome (log_syndrome),
        .log_ded      (log_ded)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        else
            passes++;
    endtask

    // Position of data bit i: the i-th position that is not a power of two.
    function automatic int pos_of(input int i);
        int cnt;
        cnt = -1;
        for (int p = 1; p <= NP; p++) begin
            if ((p & (p - 1)) != 0) begin
                cnt++;
                if (cnt == i) return p;
            end
        end
        return 0;
    endfunction

    // Check bits are the XOR of the positions of the set data bits.
    function automatic logic [RW:0] enc(input logic [DW-1:0] d);
        int s;
        logic [RW-1:0] p;
        s = 0;
        for (int i = 0; i < DW; i++) if (d[i]) s = s ^ pos_of(i);
        p = RW'(s);
        return {p, (^d) ^ (^p)};
    endfunction

    typedef struct packed {
        logic [DW-1:0] data;
        logic          sec;
        logic          ded;
        logic [RW-1:0] syn;
    } exp_t;

    // Syndrome = XOR of the positions of every set codeword bit.
    function automatic exp_t model(input logic [DW-1:0] d, input logic [RW:0] e, input logic c);
        exp_t r;
        int s;
        logic ovf;
        s = 0;
        for (int i = 0; i < DW; i++) if (d[i]) s = s ^ pos_of(i);
        for (int k = 0; k < RW; k++) if (e[k+1]) s = s ^ (1 << k);
        ovf = (^d) ^ (^e);
        r.syn  = RW'(s);
        r.sec  = ovf && (s <= NP);
        r.ded  = !r.sec && (ovf || s != 0);
        r.data = d;
        if (r.sec && c && s != 0)
            for (int i = 0; i < DW; i++) if (pos_of(i) == s) r.data[i] = ~d[i];
        return r;
    endfunction

    exp_t q[$];
    int          sec_m = 0;
    int          ded_m = 0;
    logic        logv_m = 1'b0;
    logic        logded_m = 1'b0;
    logic [RW-1:0] logsyn_m = '0;

    always @(negedge clk) begin
        exp_t h;
        if (!rst_n) begin
            chk("rst_out_valid", out_valid, 0);
            chk("rst_out_flags", {out_sec, out_ded}, 0);
            chk("rst_out_data", out_data, 0);
            chk("rst_out_syn", out_syndrome, 0);
            chk("rst_counts", {sec_cnt, ded_cnt}, 0);
            chk("rst_log", {log_valid, log_ded, log_syndrome}, 0);
            q.delete();
            sec_m = 0; ded_m = 0; logv_m = 0; logded_m = 0; logsyn_m = '0;
        end else begin
            chk("in_ready", in_ready, (q.size() < 2) || out_ready);
            if (q.size() == 0)
                chk("idle_out_valid", out_valid, 0);
            else if (out_valid === 1'b1) begin
                chk("m_out_data", out_data, q[0].data);
                chk("m_out_sec", out_sec, q[0].sec);
                chk("m_out_ded", out_ded, q[0].ded);
                chk("m_out_syn", out_syndrome, q[0].syn);
            end
            chk("m_sec_cnt", sec_cnt, sec_m);
            chk("m_ded_cnt", ded_cnt, ded_m);
            chk("m_log_valid", log_valid, logv_m);
            chk("m_log_syn", log_syndrome, logsyn_m);
            chk("m_log_ded", log_ded, logded_m);
            if (stat_clr) begin
                sec_m = 0; ded_m = 0; logv_m = 0; logded_m = 0; logsyn_m = '0;
            end
            if (out_valid === 1'b1 && out_ready && q.size() > 0) begin
                h = q.pop_front();
                if (h.sec) sec_m = (sec_m < CMAX) ? sec_m + 1 : CMAX;
                if (h.ded) ded_m = (ded_m < CMAX) ? ded_m + 1 : CMAX;
                if ((h.sec || h.ded) && !logv_m) begin
                    logv_m = 1; logsyn_m = h.syn; logded_m = h.ded;
                end
            end
            if (in_valid && in_ready === 1'b1)
                q.push_back(model(in_data, in_ecc, corr_en));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called just after a rising edge; returns just after the accept edge.
    task automatic send(input logic [DW-1:0] d, input logic [RW:0] e, input logic c);
        int n;
        n = 0;
        in_valid = 1'b1; in_data = d; in_ecc = e; corr_en = c;
        @(negedge clk);
        while (in_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (in_ready !== 1'b1) chk("send_timeout", in_ready, 1);
        step();
        in_valid = 1'b0;
    endtask

    task automatic wait_out(input string nm, input logic [DW-1:0] d, input logic s,
                            input logic dd, input logic [RW-1:0] sy);
        int n;
        n = 0;
        @(negedge clk);
        while (out_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_valid"}, out_valid, 1);
        chk({nm, "_data"}, out_data, d);
        chk({nm, "_flags"}, {out_sec, out_ded}, {s, dd});
        chk({nm, "_syn"}, out_syndrome, sy);
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [DW-1:0] w;
        logic [RW:0]   e;
        logic [DW-1:0] bd [4];
        logic [RW:0]   be [4];
        int idx, acc, guard;
        exp_t m;

        w = 32'hDEADBEEF;
        e = enc(w);

        // Model pins against hand-derived syndromes.
        m = model(w ^ 32'h1, e, 1'b1);
        chk("pin_single", {m.data, m.sec, m.ded, m.syn}, {32'hDEADBEEF, 1'b1, 1'b0, 6'd3});
        m = model(w ^ 32'h3, e, 1'b1);
        chk("pin_double", {m.sec, m.ded, m.syn}, {1'b0, 1'b1, 6'd6});
        m = model(w, e ^ 7'h52, 1'b1);
        chk("pin_invalid", {m.sec, m.ded, m.syn}, {1'b0, 1'b1, 6'd41});

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", in_ready, 1);
        step();

        // Clean word and latency
        send(w, e, 1'b1);
        @(negedge clk);
        chk("lat_not_yet", out_valid, 0);
        @(negedge clk);
        chk("lat_valid", out_valid, 1);
        chk("clean_data", out_data, 32'hDEADBEEF);
        chk("clean_flags", {out_sec, out_ded, out_syndrome}, 0);
        step();

        // Single data-bit error, corrected then detect-only
        send(w ^ 32'h1, e, 1'b1);
        wait_out("sec_corr", 32'hDEADBEEF, 1'b1, 1'b0, 6'd3);
        @(negedge clk);
        chk("sec_cnt_1", sec_cnt, 1);
        chk("log_first", {log_valid, log_ded, log_syndrome}, {1'b1, 1'b0, 6'd3});
        step();
        send(w ^ 32'h1, e, 1'b0);
        wait_out("sec_detect", 32'hDEADBEEE, 1'b1, 1'b0, 6'd3);

        // Double, p0-only and invalid-syndrome errors
        send(w ^ 32'h3, e, 1'b1);
        wait_out("ded_double", 32'hDEADBEEC, 1'b0, 1'b1, 6'd6);
        @(negedge clk);
        chk("ded_cnt_1", ded_cnt, 1);
        chk("log_kept", {log_valid, log_ded, log_syndrome}, {1'b1, 1'b0, 6'd3});
        step();
        send(w, e ^ 7'h01, 1'b1);
        wait_out("p0_only", 32'hDEADBEEF, 1'b1, 1'b0, 6'd0);
        send(w, e ^ 7'h52, 1'b1);
        wait_out("ded_invalid", 32'hDEADBEEF, 1'b0, 1'b1, 6'd41);

        // Saturation: fifth SEC beat keeps the count at all-ones
        send(w ^ 32'h1, e, 1'b1);
        send(w ^ 32'h1, e, 1'b1);
        repeat (4) step();
        @(negedge clk);
        chk("sec_sat", sec_cnt, 3);
        chk("ded_cnt_2", ded_cnt, 2);
        step();

        // Clear coincident with a SEC handshake
        send(w ^ 32'h1, e, 1'b1);
        step();
        stat_clr = 1'b1;
        step();
        stat_clr = 1'b0;
        @(negedge clk);
        chk("clr_sec_cnt", sec_cnt, 1);
        chk("clr_ded_cnt", ded_cnt, 0);
        chk("clr_log", {log_valid, log_ded, log_syndrome}, {1'b1, 1'b0, 6'd3});
        step();

        // Backpressure
        bd[0] = w ^ 32'h1;        be[0] = e;
        bd[1] = 32'h12345678;     be[1] = enc(32'h12345678);
        bd[2] = w ^ 32'h3;        be[2] = e;
        bd[3] = 32'hA5A5A5A5;     be[3] = enc(32'hA5A5A5A5) ^ 7'h01;
        out_ready = 1'b0;
        idx = 0;
        acc = 0;
        for (int cyc = 0; cyc < 5; cyc++) begin
            in_valid = 1'b1; in_data = bd[idx]; in_ecc = be[idx]; corr_en = 1'b1;
            @(negedge clk);
            if (in_ready === 1'b1) begin
                acc++;
                idx++;
            end
            step();
        end
        chk("bp_accepted", acc, 2);
        @(negedge clk);
        chk("bp_in_ready_low", in_ready, 0);
        chk("bp_out_held", out_data, 32'hDEADBEEF);
        step();
        out_ready = 1'b1;
        guard = 0;
        while (idx < 4 && guard < 50) begin
            in_valid = 1'b1; in_data = bd[idx]; in_ecc = be[idx]; corr_en = 1'b1;
            @(negedge clk);
            if (in_ready === 1'b1) idx++;
            step();
            guard++;
        end
        in_valid = 1'b0;
        repeat (5) step();
        @(negedge clk);
        chk("bp_drained", q.size(), 0);
        chk("bp_sec_cnt", sec_cnt, 3);
        chk("bp_ded_cnt", ded_cnt, 1);
        step();

        // Mid-stream reset with two beats in flight
        out_ready = 1'b0;
        send(w ^ 32'h1, e, 1'b1);
        send(w ^ 32'h3, e, 1'b1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mrst_out", {out_valid, out_sec, out_ded, out_data}, 0);
        chk("mrst_counts", {sec_cnt, ded_cnt, log_valid}, 0);
        step();
        step();
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("mrst_in_ready", in_ready, 1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("mrst_no_stale", out_valid, 0);
        end
        step();
        send(32'h0F0F0F0F, enc(32'h0F0F0F0F), 1'b1);
        wait_out("after_rst", 32'h0F0F0F0F, 1'b0, 1'b0, 6'd0);
        repeat (2) step();

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
